// File: rtl/game_speed_ctrl.sv
// Rotary-encoder game speed controller: synchronizes and debounces the encoder,
// tracks a pending speed level and emits game ticks whose period follows the active level.
module game_speed_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int DIV0         = 20,
  parameter int DIV1         = 10,
  parameter int DIV2         = 5,
  parameter int DIV3         = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sia,
  input  logic       sib,
  input  logic       sw,
  output logic       tick,
  output logic       clk_game,
  output logic [1:0] speed,
  output logic       speed_chg
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DEB_N  = (DEBOUNCE_CYC < 1) ? 1 :
                          (DEBOUNCE_CYC > 65535) ? 65535 : DEBOUNCE_CYC;
  localparam logic [15:0] DEB_LAST = 16'(DEB_N - 1);
  // Lane order {sw, b, a}; released switch idles high.
  localparam logic [2:0] DB_RST = 3'b100;

  function automatic logic [23:0] div_last(input int d);
    int dc;
    dc = (d < 2) ? 2 : ((d > 24'hFFFFFF) ? 24'hFFFFFF : d);
    return 24'(dc - 1);
  endfunction

  localparam logic [23:0] P0_LAST = div_last(DIV0);
  localparam logic [23:0] P1_LAST = div_last(DIV1);
  localparam logic [23:0] P2_LAST = div_last(DIV2);
  localparam logic [23:0] P3_LAST = div_last(DIV3);

  function automatic logic [23:0] period_last(input logic [1:0] lvl);
    logic [23:0] r;
    case (lvl)
      2'd0:    r = P0_LAST;
      2'd1:    r = P1_LAST;
      2'd2:    r = P2_LAST;
      default: r = P3_LAST;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // Reset: asynchronous assertion, deassertion retimed through two flops
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Stage p0: input synchronizer chains
  logic [SYNC_N-1:0] a_sync_p0;
  logic [SYNC_N-1:0] b_sync_p0;
  logic [SYNC_N-1:0] sw_sync_p0;
  logic [2:0]        raw_p0;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      a_sync_p0  <= '0;
      b_sync_p0  <= '0;
      sw_sync_p0 <= '1;
    end else begin
      a_sync_p0  <= {a_sync_p0[SYNC_N-2:0], sia};
      b_sync_p0  <= {b_sync_p0[SYNC_N-2:0], sib};
      sw_sync_p0 <= {sw_sync_p0[SYNC_N-2:0], sw};
    end
  end

  assign raw_p0 = {sw_sync_p0[SYNC_N-1], b_sync_p0[SYNC_N-1], a_sync_p0[SYNC_N-1]};

  // Stage p1: per-lane debounce, level accepted after DEB_N disagreeing cycles
  logic [15:0] deb_cnt_p1 [3];
  logic [2:0]  db_p1;
  logic [2:0]  db_p2;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < 3; i++) deb_cnt_p1[i] <= '0;
      db_p1 <= DB_RST;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw_p0[i] == db_p1[i]) begin
          deb_cnt_p1[i] <= '0;
        end else if (deb_cnt_p1[i] == DEB_LAST) begin
          deb_cnt_p1[i] <= '0;
          db_p1[i]      <= raw_p0[i];
        end else begin
          deb_cnt_p1[i] <= deb_cnt_p1[i] + 16'd1;
        end
      end
    end
  end

  // Stage p2: edge detection and pending speed
  logic       a_rise;
  logic       b_rise;
  logic       sw_fall;
  logic [1:0] pend;
  logic [1:0] pend_nxt;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) db_p2 <= DB_RST;
    else            db_p2 <= db_p1;
  end

  assign a_rise  = db_p1[0] & ~db_p2[0];
  assign b_rise  = db_p1[1] & ~db_p2[1];
  assign sw_fall = ~db_p1[2] & db_p2[2];

  // The switch wins over rotation; a rotation edge counts only while the other phase is low.
  always_comb begin
    pend_nxt = pend;
    if (sw_fall)
      pend_nxt = 2'd0;
    else if (a_rise && !b_rise && !db_p1[1])
      pend_nxt = sat_inc(pend);
    else if (b_rise && !a_rise && !db_p1[0])
      pend_nxt = sat_dec(pend);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) pend <= 2'd0;
    else            pend <= pend_nxt;
  end

  // Tick generator: active speed only reloads at a period boundary
  logic [23:0] tick_cnt;

  assign tick      = (tick_cnt == period_last(speed));
  assign speed_chg = tick && (pend != speed);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tick_cnt <= '0;
      speed    <= 2'd0;
      clk_game <= 1'b0;
    end else if (tick) begin
      tick_cnt <= '0;
      speed    <= pend;
      clk_game <= ~clk_game;
    end else begin
      tick_cnt <= tick_cnt + 24'd1;
    end
  end

endmodule

// File: doc/game_speed_ctrl.md
GAME_SPEED_CTRL -- requirements
Module: game_speed_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per encoder input (min 2).
REQ-002 Parameter DEBOUNCE_CYC, default 16, consecutive stable clk cycles required to accept an input level (1..65535).
REQ-003 Parameters DIV0/DIV1/DIV2/DIV3, defaults 20/10/5/2, tick period in clk cycles for speed levels 0..3 (each 2..2^24-1).
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst_n  input  1  reset; one clock, asynchronous assertion, active-low.
REQ-006 sia  input  1  encoder phase A, asynchronous, clockwise detent leads with A.
REQ-007 sib  input  1  encoder phase B, asynchronous, counter-clockwise detent leads with B.
REQ-008 sw  input  1  encoder push switch, asynchronous, active-low (0 = pressed).
REQ-009 tick  output  1  single-cycle game-step strobe.
REQ-010 clk_game  output  1  square wave, toggles on every tick.
REQ-011 speed  output  2  active speed level 0..3.
REQ-012 speed_chg  output  1  single-cycle pulse when active speed changes.

Function
REQ-013 Each of sia, sib, sw SHALL pass through a SYNC_STAGES-deep flop chain before any use.
REQ-014 Each synchronized input SHALL have its own debounce counter; the debounced level SHALL take the synchronized value only after DEBOUNCE_CYC consecutive cycles of disagreement, counter cleared on any agreement cycle.
REQ-015 Input-to-debounced latency SHALL be SYNC_STAGES+DEBOUNCE_CYC cycles (±1 for asynchronous sampling); shorter pulses SHALL have no effect.
REQ-016 Rising edge of debounced A while debounced B=0 SHALL increment pending speed, saturating at 3.
REQ-017 Rising edge of debounced B while debounced A=0 SHALL decrement pending speed, saturating at 0.
REQ-018 Rising edges of debounced A and B in the same cycle, or an edge while the other phase is 1, SHALL leave pending speed unchanged.
REQ-019 Falling edge of debounced sw SHALL set pending speed to 0; this SHALL take priority over a rotation edge in the same cycle.
REQ-020 Tick counter SHALL count 0..P-1, P = DIVn of the active speed; tick=1 in the cycle count==P-1, after which count wraps to 0.
REQ-021 Active speed SHALL load from pending speed only in a tick cycle; period change therefore takes effect for the period starting after that tick, never mid-period.
REQ-022 speed_chg SHALL be 1 exactly in the tick cycle where the loaded value differs from the current active speed; speed output updates on the following clock edge.
REQ-023 clk_game SHALL toggle on the clock edge ending each tick cycle (period 2P, 50% duty).
REQ-024 Multiple rotation edges within one tick period SHALL all accumulate into pending speed (with saturation); only the final value is loaded.
REQ-025 Counter width SHALL be 24 bits; no parameter value within range SHALL cause overflow or a zero-length period.

Reset
REQ-026 While rst_n=0 all flops SHALL be forced asynchronously: tick=0, clk_game=0, speed=0, speed_chg=0, pending speed=0, tick counter=0, debounce counters=0.
REQ-027 Synchronizer and debounced states SHALL reset to A=0, B=0, sw=1 (released) so reset release produces no spurious edge.
REQ-028 Reset deassertion SHALL be synchronized internally; first tick SHALL occur DIV0 cycles after the first clock edge with rst_n=1.
REQ-029 Reset asserted mid-period SHALL discard the pending speed and partial count; no tick or speed_chg is emitted.

Verification
REQ-030 Reset release, inputs idle (A=0,B=0,sw=1) -> tick every 20 cycles, clk_game period 40, speed=0, speed_chg never 1.
REQ-031 One clean CW detent (A high with B=0, held 40 cycles) -> no change until next tick; at that tick speed_chg=1, then speed=1 and ticks every 10 cycles.
REQ-032 Five CW detents -> speed steps 1,2,3 and saturates at 3 (tick every 2 cycles); fifth detent produces no speed_chg.
REQ-033 10-cycle glitch on sia with DEBOUNCE_CYC=16 -> pending and active speed unchanged, no speed_chg.
REQ-034 At speed 3, sw press coincident with CW detent -> next tick speed_chg=1, speed=0, period returns to 20.
REQ-035 rst_n pulsed low for 3 cycles mid-period at speed 2 -> all outputs 0 immediately; first tick 20 cycles after release.
